// File: rtl/trap_csr_sequencer_if.sv
// Trap sequencer bus: trap request/capture inputs, shared CSR write port and
// pipeline stall/redirect outputs.
//  master : trap unit / CSR file / pipeline side (drives requests and CSRWrReady)
//  slave  : trap_csr_sequencer (drives CSR write port, busy, done, handler PC)
interface trap_csr_sequencer_if #(
  parameter int unsigned XLEN = 64
);
  // trap request and state captured at acceptance
  logic            TrapReqM;
  logic            InterruptReqM;
  logic            TrapToM;
  logic            TrapToHS;
  logic            TrapToVS;
  logic [3:0]      CauseReqM;
  logic [1:0]      PrivReqW;
  logic [XLEN-1:0] EPCReqM;
  logic [XLEN-1:0] TvalReqM;
  logic [XLEN-1:0] MTVEC;
  logic [XLEN-1:0] STVEC;
  logic [XLEN-1:0] VSTVEC;
  logic [XLEN-1:0] StatusCurM;

  // shared CSR write port
  logic            CSRWrReady;
  logic            CSRWrEn;
  logic [11:0]     CSRWrAddr;
  logic [XLEN-1:0] CSRWrData;

  // pipeline control
  logic            TrapBusyM;
  logic            TrapDoneM;
  logic [XLEN-1:0] TrapPCM;

  modport master (
    output TrapReqM, InterruptReqM, TrapToM, TrapToHS, TrapToVS, CauseReqM,
           PrivReqW, EPCReqM, TvalReqM, MTVEC, STVEC, VSTVEC, StatusCurM,
           CSRWrReady,
    input  CSRWrEn, CSRWrAddr, CSRWrData, TrapBusyM, TrapDoneM, TrapPCM
  );

  modport slave (
    input  TrapReqM, InterruptReqM, TrapToM, TrapToHS, TrapToVS, CauseReqM,
           PrivReqW, EPCReqM, TvalReqM, MTVEC, STVEC, VSTVEC, StatusCurM,
           CSRWrReady,
    output CSRWrEn, CSRWrAddr, CSRWrData, TrapBusyM, TrapDoneM, TrapPCM
  );
endinterface

// File: rtl/trap_csr_sequencer.sv
// Trap entry sequencer. On an accepted trap it captures cause/EPC/tval/target,
// then issues xEPC, xCAUSE, xTVAL and xSTATUS writes over one shared CSR write
// port (each held until CSRWrReady) and finally pulses TrapDoneM with the
// handler PC derived from the target's xTVEC.
// Ports:
//  clk    clock
//  reset  asynchronous, active-high reset
//  bus    trap_csr_sequencer_if.slave: trap request inputs, CSR write port
//         (CSRWrEn/Addr/Data, CSRWrReady), TrapBusyM, TrapDoneM, TrapPCM
module trap_csr_sequencer #(
  parameter int unsigned XLEN               = 64,
  parameter bit          VECTORED_SUPPORTED = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  trap_csr_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    WR_EPC,
    WR_CAUSE,
    WR_TVAL,
    WR_STATUS,
    REDIRECT
  } stateT;

  typedef enum logic [1:0] {
    TARGET_M,
    TARGET_HS,
    TARGET_VS
  } targetT;

  localparam logic [11:0] EPC_OFS   = 12'h041;
  localparam logic [11:0] CAUSE_OFS = 12'h042;
  localparam logic [11:0] TVAL_OFS  = 12'h043;

  stateT           state;
  logic [11:0]     addrBase;
  logic [XLEN-1:0] causeData;
  logic [XLEN-1:0] tvalData;
  logic [XLEN-1:0] statusData;
  logic [XLEN-1:0] trapPc;

  targetT          targetC;
  logic [3:0]      codeC;
  logic [11:0]     addrBaseC;
  logic [XLEN-1:0] tvecC;
  logic [XLEN-1:0] tvecBaseC;
  logic            vectoredC;
  logic [XLEN-1:0] epcDataC;
  logic [XLEN-1:0] causeDataC;
  logic [XLEN-1:0] tvalDataC;
  logic [XLEN-1:0] statusDataC;
  logic [XLEN-1:0] trapPcC;

  // Everything written later is derived from the live request inputs, so the
  // capture edge freezes the whole sequence and later input changes are moot.
  always_comb begin
    targetC = TARGET_M;
    if (bus.TrapToM)       targetC = TARGET_M;
    else if (bus.TrapToHS) targetC = TARGET_HS;
    else if (bus.TrapToVS) targetC = TARGET_VS;

    // VS-level interrupts are reported with their S-level codes (VSSI/VSTI/VSEI -> SSI/STI/SEI)
    codeC = bus.CauseReqM;
    if ((targetC == TARGET_VS) && bus.InterruptReqM &&
        ((bus.CauseReqM == 4'd2) || (bus.CauseReqM == 4'd6) || (bus.CauseReqM == 4'd10)))
      codeC = bus.CauseReqM - 4'd1;

    case (targetC)
      TARGET_HS: begin addrBaseC = 12'h100; tvecC = bus.STVEC;  end
      TARGET_VS: begin addrBaseC = 12'h200; tvecC = bus.VSTVEC; end
      default:   begin addrBaseC = 12'h300; tvecC = bus.MTVEC;  end
    endcase

    epcDataC   = {bus.EPCReqM[XLEN-1:1], 1'b0};
    causeDataC = {bus.InterruptReqM, {(XLEN-5){1'b0}}, codeC};
    tvalDataC  = bus.InterruptReqM ? '0 : bus.TvalReqM;

    // Stack interrupt enable into the previous-enable bit and record prior privilege
    statusDataC = bus.StatusCurM;
    if (targetC == TARGET_M) begin
      statusDataC[7]     = bus.StatusCurM[3];
      statusDataC[3]     = 1'b0;
      statusDataC[12:11] = bus.PrivReqW;
    end else begin
      statusDataC[5]     = bus.StatusCurM[1];
      statusDataC[1]     = 1'b0;
      statusDataC[8]     = bus.PrivReqW[0];
    end

    // MODE 10/11 are reserved and fall back to direct
    tvecBaseC = {tvecC[XLEN-1:2], 2'b00};
    vectoredC = VECTORED_SUPPORTED && (tvecC[1:0] == 2'b01) && bus.InterruptReqM;
    trapPcC   = vectoredC ? (tvecBaseC + XLEN'({codeC, 2'b00})) : tvecBaseC;
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      addrBase      <= '0;
      causeData     <= '0;
      tvalData      <= '0;
      statusData    <= '0;
      trapPc        <= '0;
      bus.CSRWrEn   <= 1'b0;
      bus.CSRWrAddr <= '0;
      bus.CSRWrData <= '0;
      bus.TrapBusyM <= 1'b0;
      bus.TrapDoneM <= 1'b0;
      bus.TrapPCM   <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.TrapDoneM <= 1'b0;
          if (bus.TrapReqM) begin
            addrBase      <= addrBaseC;
            causeData     <= causeDataC;
            tvalData      <= tvalDataC;
            statusData    <= statusDataC;
            trapPc        <= trapPcC;
            bus.CSRWrEn   <= 1'b1;
            bus.CSRWrAddr <= addrBaseC | EPC_OFS;
            bus.CSRWrData <= epcDataC;
            bus.TrapBusyM <= 1'b1;
            state         <= WR_EPC;
          end
        end
        WR_EPC: begin
          if (bus.CSRWrReady) begin
            bus.CSRWrAddr <= addrBase | CAUSE_OFS;
            bus.CSRWrData <= causeData;
            state         <= WR_CAUSE;
          end
        end
        WR_CAUSE: begin
          if (bus.CSRWrReady) begin
            bus.CSRWrAddr <= addrBase | TVAL_OFS;
            bus.CSRWrData <= tvalData;
            state         <= WR_TVAL;
          end
        end
        WR_TVAL: begin
          if (bus.CSRWrReady) begin
            bus.CSRWrAddr <= addrBase;
            bus.CSRWrData <= statusData;
            state         <= WR_STATUS;
          end
        end
        WR_STATUS: begin
          if (bus.CSRWrReady) begin
            bus.CSRWrEn   <= 1'b0;
            bus.CSRWrAddr <= '0;
            bus.CSRWrData <= '0;
            bus.TrapDoneM <= 1'b1;
            bus.TrapPCM   <= trapPc;
            state         <= REDIRECT;
          end
        end
        REDIRECT: begin
          // requests arriving here are dropped; the next IDLE cycle may accept
          bus.TrapDoneM <= 1'b0;
          bus.TrapBusyM <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          bus.CSRWrEn   <= 1'b0;
          bus.TrapBusyM <= 1'b0;
          bus.TrapDoneM <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule
